uc_rr_arbiter: RTL
==================

# uc_rr_arbiter

Parametrised unit-clause arbiter that sits between the BCP engines' outgoing unit-clause queues and the broadcast path (engine input queues, mstack, global state table). It collects implied literals from `NUM_ENG` engines with round-robin fairness and checks each against an internal assignment table. Duplicates are dropped and opposite-polarity hits raise a sticky conflict. New literals are broadcast one per cycle under backpressure. Unlike the fixed single-mode arbiter, it is generic in engine count and literal width, has an init phase, keeps an assigned-variable count, and supports a synchronous restart.

## Interface
- `NUM_ENG`, 4: number of engine channels (≥2).
- `LIT_W`, 8: literal width. Bit `LIT_W-1` is polarity (1 = negated); bits `LIT_W-2:0` are the variable index. The table holds `2**(LIT_W-1)` variables.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clear` in 1: synchronous restart (table wipe, return to INIT).
- `init_lit` in `LIT_W`: initial-assignment literal.
- `init_valid` in 1: `init_lit` is offered.
- `init_ready` out 1: an init literal is accepted this cycle.
- `init_done` in 1: last init literal has been sent; move to RUN.
- `eng_lit` in `NUM_ENG*LIT_W`: head literal of each engine UCQ; engine i occupies bits `[i*LIT_W +: LIT_W]`.
- `eng_valid` in `NUM_ENG`: UCQ i is non-empty.
- `eng_stall` in `NUM_ENG`: engine i is idle.
- `eng_pop` out `NUM_ENG`: pop the head of UCQ i (one-hot or zero).
- `bcast_full` in `NUM_ENG+1`: bits `NUM_ENG-1:0` are the engine input queues; bit `NUM_ENG` is the mstack.
- `bcast_lit` out `LIT_W`: broadcast literal.
- `bcast_push` out 1: push `bcast_lit` to all engine queues and the mstack.
- `gst_lit` out `LIT_W`: copy of `bcast_lit` for the GST.
- `gst_valid` out 1: equal to `bcast_push`.
- `conflict` out 1: sticky conflict flag.
- `stall` out 1: global quiescence.
- `assigned_cnt` out `LIT_W`: number of assigned variables.

## Operation
- **Assignment table.** One `{assigned, value}` pair per variable. Lookup is combinational on the candidate literal; the write lands at the clock edge that accepts the literal.
- **States.** INIT → RUN → CONFLICT. `clear` moves any state to INIT.
- **INIT.**
  - `init_ready = (state==INIT) && ~|bcast_full`.
  - An init literal is accepted when `init_valid && init_ready`; it then gets the table check below.
  - `eng_pop` is held at 0.
  - `init_done` moves to RUN, unless the literal accepted in the same cycle conflicts; that case goes to CONFLICT.
- **RUN, grant.** No grant if `|bcast_full`. Otherwise grant the first engine with `eng_valid` set, searching from `rr_ptr` upward modulo `NUM_ENG`.
  - `eng_pop[g]` pulses for exactly one cycle.
  - After a grant to g, `rr_ptr ← (g+1) mod NUM_ENG`. With no grant, `rr_ptr` is unchanged.
- **Table check on an accepted literal L with variable v:**
  - v unassigned: write `{1, ~L[LIT_W-1]}`, increment `assigned_cnt`, broadcast L.
  - v assigned with the same value: drop silently. The pop still happens; no push.
  - v assigned with the opposite value: go to CONFLICT and set `conflict`. No push, no table write.
- **CONFLICT.**
  - `conflict` held at 1.
  - `eng_pop` and `init_ready` held at 0.
  - `bcast_push` is 0 from the next cycle on.
  - Exit only via `clear` or reset.
- **Stall.** `stall = (state==RUN) && ~|eng_valid && &eng_stall && ~bcast_push`.
- **`assigned_cnt`.** Saturates at `2**(LIT_W-1)`. This cannot overflow, because `LIT_W` bits cover `2**(LIT_W-1)`.

## Timing
- **Reset** (`rst_n` low, asynchronous):
  - state INIT, table all unassigned, `rr_ptr`=0.
  - `conflict`, `bcast_push`, `gst_valid`, `stall`, `eng_pop` = 0.
  - `bcast_lit`, `gst_lit`, `assigned_cnt` = 0.
  - `init_ready` is 1 one cycle after release, if no `bcast_full` bit is set.
- **`clear`** behaves exactly like reset, one cycle later (synchronous). Clearing mid-broadcast aborts it: `bcast_push` is 0 in the next cycle.
- **Latency.** Acceptance in cycle t (pop or `init_ready`) gives registered `bcast_push`/`gst_valid`/`bcast_lit` in t+1. A conflict detected in t gives `conflict`=1 in t+1.
- **Throughput.** One literal per cycle. A back-to-back same-variable literal in t+1 sees the table write made at the end of t.
- **Backpressure.** `bcast_full` is sampled in the acceptance cycle. A push in t+1 is guaranteed to have had room when it was accepted.

## Test plan
- **Reset/init.** Release reset; send init 0x05, then 0x8A with `init_done` → `bcast_push` in the 2 cycles after acceptance with lit 0x05, then 0x8A; `assigned_cnt`=2; state RUN.
- **Round-robin.** All 4 engines valid with 0x11, 0x12, 0x13, 0x14 and `rr_ptr`=0 → pops 0, 1, 2, 3 on consecutive cycles; broadcasts 0x11 to 0x14 each one cycle later.
- **Duplicate.** Engines 1 and 2 both present 0x20 → two pops, one push of 0x20; `assigned_cnt` +1.
- **Conflict.** x5 assigned by 0x05; engine 3 presents 0x85 → `eng_pop[3]`, no push, `conflict`=1 the next cycle; no further pops; `clear` → `conflict`=0, `assigned_cnt`=0, INIT.
- **Backpressure.** `bcast_full[4]`=1 for 3 cycles while engine 0 is valid → no pop, `rr_ptr` unchanged; first pop in the cycle after the bit drops.
- **Stall.** All engines stalled and empty in RUN, no push pending → `stall`=1; raise `eng_valid[2]` → `stall`=0 combinationally in the same cycle.

Source files
------------

// File: rtl/uc_rr_arbiter_if.sv
// Bundle of the unit-clause arbiter's data and handshake signals.
// The slave modport is the arbiter, and the master modport is its surroundings.
interface uc_rr_arbiter_if #(
    parameter int NUM_ENG = 4,
    parameter int LIT_W   = 8
);
    logic                       clear;
    logic [LIT_W-1:0]           init_lit;
    logic                       init_valid;
    logic                       init_ready;
    logic                       init_done;
    logic [NUM_ENG*LIT_W-1:0]   eng_lit;
    logic [NUM_ENG-1:0]         eng_valid;
    logic [NUM_ENG-1:0]         eng_stall;
    logic [NUM_ENG-1:0]         eng_pop;
    logic [NUM_ENG:0]           bcast_full;
    logic [LIT_W-1:0]           bcast_lit;
    logic                       bcast_push;
    logic [LIT_W-1:0]           gst_lit;
    logic                       gst_valid;
    logic                       conflict;
    logic                       stall;
    logic [LIT_W-1:0]           assigned_cnt;

    modport slave (
        input  clear, init_lit, init_valid, init_done,
               eng_lit, eng_valid, eng_stall, bcast_full,
        output init_ready, eng_pop, bcast_lit, bcast_push,
               gst_lit, gst_valid, conflict, stall, assigned_cnt
    );

    modport master (
        output clear, init_lit, init_valid, init_done,
               eng_lit, eng_valid, eng_stall, bcast_full,
        input  init_ready, eng_pop, bcast_lit, bcast_push,
               gst_lit, gst_valid, conflict, stall, assigned_cnt
    );
endinterface

// File: rtl/uc_rr_arbiter.sv
// Round-robin unit-clause arbiter: dedups implied literals against an assignment
// table, broadcasts new ones one per cycle, and flags opposite-polarity hits.
module uc_rr_arbiter #(
    parameter int NUM_ENG = 4,
    parameter int LIT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    uc_rr_arbiter_if.slave    bus
);
    localparam int VAR_W = LIT_W - 1;
    localparam int NVAR  = 2 ** VAR_W;
    localparam int PTR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    localparam logic [1:0] ST_INIT     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_CONFLICT = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NVAR-1:0]   asg_q;
    logic [NVAR-1:0]   val_q;
    logic              push_q;
    logic [LIT_W-1:0]  lit_q;
    logic [LIT_W-1:0]  cnt_q;

    logic [LIT_W-1:0]  eng_lit_arr [NUM_ENG];
    logic              any_full;
    logic              init_rdy;
    logic              init_acc;
    logic              grant_hit;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  cand_idx;
    logic              run_grant;
    logic              accept;
    logic [LIT_W-1:0]  cand_lit;
    logic [VAR_W-1:0]  cand_var;
    logic              cand_val;
    logic              is_new;
    logic              is_conf;

    always_comb begin
        for (int i = 0; i < NUM_ENG; i++) begin
            eng_lit_arr[i] = bus.eng_lit[i*LIT_W +: LIT_W];
        end
    end

    assign any_full = |bus.bcast_full;
    assign init_rdy = (state_q == ST_INIT) && !any_full;
    assign init_acc = bus.init_valid && init_rdy;

    // First valid engine at or after rr_ptr, wrapping modulo NUM_ENG.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_ENG; k++) begin
            cand_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_ENG);
            if (!grant_hit && bus.eng_valid[cand_idx]) begin
                grant_hit = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    assign run_grant = (state_q == ST_RUN) && !any_full && grant_hit;
    assign accept    = init_acc || run_grant;
    assign cand_lit  = init_acc ? bus.init_lit : eng_lit_arr[grant_idx];
    assign cand_var  = cand_lit[VAR_W-1:0];
    assign cand_val  = ~cand_lit[LIT_W-1];
    assign is_new    = accept && !asg_q[cand_var];
    assign is_conf   = accept && asg_q[cand_var] && (val_q[cand_var] != cand_val);
    assign rr_ptr_d  = PTR_W'((int'(grant_idx) + 1) % NUM_ENG);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                if (is_conf)            state_d = ST_CONFLICT;
                else if (bus.init_done) state_d = ST_RUN;
            end
            ST_RUN:      if (is_conf) state_d = ST_CONFLICT;
            ST_CONFLICT: state_d = ST_CONFLICT;
            default:     state_d = ST_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    // NOTE: the table is plain flops, not a RAM, so it is wiped by reset and clear in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            rr_ptr_q <= '0;
            asg_q    <= '0;
            val_q    <= '0;
            push_q   <= 1'b0;
            lit_q    <= '0;
            cnt_q    <= '0;
        end else if (bus.clear) begin
            state_q  <= ST_INIT;
            rr_ptr_q <= '0;
            asg_q    <= '0;
            val_q    <= '0;
            push_q   <= 1'b0;
            lit_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            push_q  <= is_new;
            if (run_grant) rr_ptr_q <= rr_ptr_d;
            if (is_new) begin
                lit_q           <= cand_lit;
                asg_q[cand_var] <= 1'b1;
                val_q[cand_var] <= cand_val;
                if (cnt_q != LIT_W'(NVAR)) cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.init_ready   = init_rdy;
    assign bus.eng_pop      = run_grant ? (NUM_ENG'(1) << grant_idx) : '0;
    assign bus.bcast_lit    = lit_q;
    assign bus.bcast_push   = push_q;
    assign bus.gst_lit      = lit_q;
    assign bus.gst_valid    = push_q;
    assign bus.conflict     = (state_q == ST_CONFLICT);
    assign bus.assigned_cnt = cnt_q;
    assign bus.stall        = (state_q == ST_RUN) && !(|bus.eng_valid) &&
                              (&bus.eng_stall) && !push_q;
endmodule
